// File: rtl/fetch_pkg.sv
// Shared constants and the instruction-queue entry layout for the fetch front end.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;
  localparam int INSTR_BYTES  = 4;

  // Queue entry as stored in fetch_queue: instruction in the upper bits, PC below.
  typedef struct packed {
    logic [ILEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Flush dominates: a push or pop in the flush cycle is dropped.
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Redirectable fetch PC with a one-cycle-latency imem port feeding a decoupling queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              ILEN     = ILEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  // Decode handshake: the head transfers on a cycle with out_valid && out_ready;
  // out_valid never depends on out_ready, and the head fields hold while not taken.

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              EW      = ILEN + XLEN;
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pending_q, pending_d;

  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic [EW-1:0]   q_head;
  logic            pop;
  logic [CW:0]     credit;

  assign pop    = out_valid && out_ready;
  // Slots the queue will still owe after this cycle, counting the in-flight response.
  assign credit = {1'b0, q_count} + {{CW{1'b0}}, pending_q} - {{CW{1'b0}}, pop};

  assign imem_req  = !rst && !redirect && (credit < DEPTH_W);
  assign imem_addr = fpc_q;

  always_comb begin
    fpc_d     = fpc_q;
    pend_pc_d = pend_pc_q;
    pending_d = imem_req;
    if (redirect) begin
      fpc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (imem_req) begin
      fpc_d     = fpc_q + STEP;
      pend_pc_d = fpc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q     <= RESET_PC;
      pend_pc_q <= '0;
      pending_q <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      pend_pc_q <= pend_pc_d;
      pending_q <= pending_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (pending_q),
    .wdata ({imem_rdata, pend_pc_q}),
    .pop   (pop),
    .flush (redirect),
    .rdata (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign out_valid    = !q_empty;
  assign out_instr    = q_head[EW-1:XLEN];
  assign out_pc       = q_head[XLEN-1:0];
  assign out_pc_plus4 = out_valid ? (out_pc + STEP) : '0;

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], q_full};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall, redirects, PC wrap and async reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int n_tests;
  int n_fail;

  logic [31:0] last_addr;

  fetch_unit #(
    .XLEN     (32),
    .ILEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: one-cycle read latency, data = address ^ 0xA5A5_0000.
  always @(posedge clk) last_addr <= imem_addr;
  assign imem_rdata = last_addr ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, pc ^ 32'hA5A5_0000);
    check({tag, "_pc4"}, out_pc_plus4, pc + 32'd4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b1;

    // Reset values
    tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_pc4", out_pc_plus4, 32'h0);

    // Reset release with out_ready high: head valid from cycle 2, one per cycle
    tick();
    rst = 1'b0;
    #1;
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    tick();
    check("c1_valid", {31'b0, out_valid}, 32'd0);
    check("c1_addr", imem_addr, 32'h4);
    tick();
    check_head("c2", 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_head("stream", 32'(4 * k));
    end

    // Async reset between edges: outputs return to reset values at once
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_instr", out_instr, 32'h0);
    check("arst_pc4", out_pc_plus4, 32'h0);

    // Stall from reset release: queue fills to 4, then requests stop
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("st_c0_addr", imem_addr, 32'h0);
    tick();
    tick();
    check_head("st_c2", 32'h0);
    tick();
    check("st_c3_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("st_c4_req", {31'b0, imem_req}, 32'd0);
    for (int k = 5; k <= 9; k++) tick();
    check("st_c9_req", {31'b0, imem_req}, 32'd0);
    check("st_c9_addr", imem_addr, 32'h10);
    check_head("st_c9", 32'h0);
    tick();
    out_ready = 1'b1;
    #1;
    check("st_resume_req", {31'b0, imem_req}, 32'd1);
    check_head("drain0", 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_head("drain", 32'(4 * k));
    end

    // Redirect with three entries queued and a response in flight
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("rd_req_t", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("rd_t1_valid", {31'b0, out_valid}, 32'd0);
    check("rd_t1_req", {31'b0, imem_req}, 32'd1);
    check("rd_t1_addr", imem_addr, 32'h0000_0100);
    tick();
    check("rd_t2_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check_head("rd_t3", 32'h0000_0100);
    out_ready = 1'b1;
    tick();
    check_head("rd_t4", 32'h0000_0104);

    // Redirect in the same cycle as a pop and a pending response
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    #1;
    check("rp_t1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("rp_t2_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check_head("rp_t3", 32'h0000_0200);
    tick();
    check_head("rp_t4", 32'h0000_0204);

    // Back-to-back redirects: the last target wins
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0400;
    #1;
    check("bb_req", {31'b0, imem_req}, 32'd0);
    check("bb_valid", {31'b0, out_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("bb_addr", imem_addr, 32'h0000_0400);
    tick();
    tick();
    check_head("bb_head", 32'h0000_0400);

    // PC wraps past the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    check_head("wrap0", 32'hFFFF_FFF8);
    tick();
    check("wrap1_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap1_pc4", out_pc_plus4, 32'h0);
    tick();
    check_head("wrap2", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
